// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the memory stage: instruction codes, status codes,
// the memory-stage FSM state encoding and the default data memory size.
package y86_pkg;

  localparam int MEM_BYTES_DEF = 1024;

  localparam logic [3:0] IC_HALT   = 4'h0;
  localparam logic [3:0] IC_NOP    = 4'h1;
  localparam logic [3:0] IC_RRMOVQ = 4'h2;
  localparam logic [3:0] IC_IRMOVQ = 4'h3;
  localparam logic [3:0] IC_RMMOVQ = 4'h4;
  localparam logic [3:0] IC_MRMOVQ = 4'h5;
  localparam logic [3:0] IC_OPQ    = 4'h6;
  localparam logic [3:0] IC_JXX    = 4'h7;
  localparam logic [3:0] IC_CALL   = 4'h8;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_PUSHQ  = 4'hA;
  localparam logic [3:0] IC_POPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: one synchronous write port, one asynchronous read
// port for the stage and one asynchronous debug read port with range check.
module data_mem
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata,
  input  logic [63:0]   i_dbg_addr,
  output logic [7:0]    o_dbg_data
);

  logic [7:0] r_mem [0:MEM_BYTES-1];

  // Byte write port; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Stage read port and range-checked debug read port.
  always_comb begin
    o_rdata    = 8'h00;
    o_dbg_data = 8'h00;
    if (32'(i_raddr) < MEM_BYTES) begin
      o_rdata = r_mem[i_raddr];
    end else begin
      o_rdata = 8'h00;
    end
    if (i_dbg_addr < 64'(MEM_BYTES)) begin
      o_dbg_data = r_mem[i_dbg_addr[AW-1:0]];
    end else begin
      o_dbg_data = 8'h00;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// SEQ memory stage: decodes the access, bound-checks it, then moves one byte
// per cycle (little-endian) and pulses done when valM/stat are valid.
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic [63:0] valM,
  output logic [1:0]  stat,
  output logic        busy,
  output logic        done,
  input  logic [63:0] dbg_addr,
  output logic [7:0]  dbg_data
);

  localparam int          AW       = $clog2(MEM_BYTES);
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  mem_state_t    r_state;
  logic          r_is_write;
  logic [AW-1:0] r_addr;
  logic [63:0]   r_wdata;
  logic [2:0]    r_cnt;
  logic [63:0]   r_valm;
  logic [1:0]    r_stat;
  logic          r_busy;
  logic          r_done;

  logic          w_is_mem;
  logic          w_is_write;
  logic [63:0]   w_addr;
  logic [63:0]   w_wdata;
  logic [1:0]    w_stat;
  logic          w_go_access;
  logic          w_we;
  logic [AW-1:0] w_baddr;
  logic [7:0]    w_wbyte;
  logic [7:0]    w_rbyte;

  // Decode the incoming instruction into access kind, address, data and status.
  always_comb begin
    w_is_mem   = 1'b0;
    w_is_write = 1'b0;
    w_addr     = valE;
    w_wdata    = valA;
    case (icode)
      IC_RMMOVQ, IC_PUSHQ: begin
        w_is_mem   = 1'b1;
        w_is_write = 1'b1;
      end
      IC_CALL: begin
        w_is_mem   = 1'b1;
        w_is_write = 1'b1;
        w_wdata    = valP;
      end
      IC_MRMOVQ: begin
        w_is_mem = 1'b1;
      end
      IC_POPQ, IC_RET: begin
        w_is_mem = 1'b1;
        w_addr   = valA;
      end
      default: begin
        w_is_mem = 1'b0;
      end
    endcase
    // Plain 64-bit compare: an address near 2^64 must never wrap into range.
    if (icode == IC_HALT) begin
      w_stat = STAT_HLT;
    end else if (icode > IC_POPQ) begin
      w_stat = STAT_INS;
    end else if (w_is_mem && (w_addr > ADDR_MAX)) begin
      w_stat = STAT_ADR;
    end else begin
      w_stat = STAT_AOK;
    end
    w_go_access = w_is_mem && (w_stat == STAT_AOK);
  end

  assign w_baddr = r_addr + AW'(r_cnt);
  assign w_wbyte = r_wdata[{r_cnt, 3'b000} +: 8];
  // A reset arriving mid-access must not commit the byte of that cycle.
  assign w_we    = (r_state == S_ACCESS) && r_is_write && !rst;

  data_mem #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_data_mem (
    .clk        (clk),
    .i_we       (w_we),
    .i_waddr    (w_baddr),
    .i_wdata    (w_wbyte),
    .i_raddr    (w_baddr),
    .o_rdata    (w_rbyte),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  // Sequencing FSM with registered valM/stat/busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 64'h0;
      r_cnt      <= 3'd0;
      r_valm     <= 64'h0;
      r_stat     <= STAT_AOK;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_is_write <= w_is_write;
            r_addr     <= w_addr[AW-1:0];
            r_wdata    <= w_wdata;
            r_cnt      <= 3'd0;
            r_valm     <= 64'h0;
            r_stat     <= w_stat;
            if (w_go_access) begin
              r_state <= S_ACCESS;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (!r_is_write) begin
            r_valm[{r_cnt, 3'b000} +: 8] <= w_rbyte;
          end
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign valM = r_valm;
  assign stat = r_stat;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage against a byte-array
// reference model of the Y86-64 memory stage.
module tb_memory_stage;

  localparam int MB = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic [63:0] valA = 64'h0;
  logic [63:0] valE = 64'h0;
  logic [63:0] valP = 64'h0;
  logic [63:0] valM;
  logic [1:0]  stat;
  logic        busy;
  logic        done;
  logic [63:0] dbg_addr = 64'h0;
  logic [7:0]  dbg_data;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] model_mem [0:MB-1];

  memory_stage #(.MEM_BYTES(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .icode    (icode),
    .valA     (valA),
    .valE     (valE),
    .valP     (valP),
    .valM     (valM),
    .stat     (stat),
    .busy     (busy),
    .done     (done),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Compare debug port against the model for bytes lo..hi (inclusive).
  task automatic check_mem(input string tag, input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      dbg_addr = 64'(a);
      #1;
      check_eq(tag, {56'h0, dbg_data}, {56'h0, model_mem[a]});
    end
  endtask

  // Apply one instruction; expectations come from the Y86 rules directly.
  task automatic do_op(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                       input logic [63:0] p, input bit junk);
    bit          is_mem, is_wr, seen;
    logic [63:0] addr, wdata, exp_valm;
    logic [1:0]  exp_stat;
    int          exp_lat, lat;
    is_mem = (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) || (ic == 4'h9) ||
             (ic == 4'hA) || (ic == 4'hB);
    is_wr  = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    addr   = ((ic == 4'h9) || (ic == 4'hB)) ? a : e;
    wdata  = (ic == 4'h8) ? p : a;
    if (ic == 4'h0)                            exp_stat = 2'd1;
    else if (ic > 4'hB)                        exp_stat = 2'd3;
    else if (is_mem && addr > 64'(MB - 8))     exp_stat = 2'd2;
    else                                       exp_stat = 2'd0;
    exp_lat  = (is_mem && exp_stat == 2'd0) ? 9 : 1;
    exp_valm = 64'h0;
    if (exp_lat == 9 && !is_wr) begin
      for (int k = 0; k < 8; k++) exp_valm = exp_valm | (64'(model_mem[int'(addr) + k]) << (8 * k));
    end
    @(negedge clk);
    icode = ic; valA = a; valE = e; valP = p; start = 1'b1;
    @(posedge clk);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      check_eq("busy_done_excl", {63'h0, busy & done}, 64'h0);
      if (!done) check_eq("busy", {63'h0, busy}, {63'h0, (exp_lat == 9)});
      seen = done;
      if (junk && !seen && lat < exp_lat - 1) begin
        start = 1'b1; icode = 4'($urandom()); valA = rand64(); valE = rand64(); valP = rand64();
      end else begin
        start = 1'b0;
      end
    end
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("valM", valM, exp_valm);
    check_eq("stat", {62'h0, stat}, {62'h0, exp_stat});
    @(negedge clk);
    check_eq("done_once", {63'h0, done}, 64'h0);
    check_eq("valM_held", valM, exp_valm);
    if (exp_lat == 9 && is_wr) begin
      for (int k = 0; k < 8; k++) model_mem[int'(addr) + k] = wdata[8*k +: 8];
      check_mem("wr_bytes", int'(addr), int'(addr) + 7);
    end
  endtask

  initial begin
    logic [63:0] d, ad, ea;
    logic [3:0]  ic;
    int          ndone;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_valM", valM, 64'h0);
    check_eq("rst_stat", {62'h0, stat}, 64'h0);
    check_eq("rst_busy", {63'h0, busy}, 64'h0);
    check_eq("rst_done", {63'h0, done}, 64'h0);
    dbg_addr = 64'd1024;             #1; check_eq("dbg_oob", {56'h0, dbg_data}, 64'h0);
    dbg_addr = 64'hFFFF_FFFF_FFFF_FFF8; #1; check_eq("dbg_oob_hi", {56'h0, dbg_data}, 64'h0);

    // Give every byte a known value.
    for (int i = 0; i < MB / 8; i++) do_op(4'h4, rand64(), 64'(i * 8), 64'h0, 1'b0);

    do_op(4'h4, 64'h1122334455667788, 64'd16, 64'h0, 1'b0);
    dbg_addr = 64'd16; #1; check_eq("rmmovq_b16", {56'h0, dbg_data}, 64'h88);
    dbg_addr = 64'd23; #1; check_eq("rmmovq_b23", {56'h0, dbg_data}, 64'h11);
    do_op(4'h5, 64'h0, 64'd16, 64'h0, 1'b1);
    do_op(4'h8, 64'h0, 64'd1016, 64'hABC, 1'b0);
    dbg_addr = 64'd1016; #1; check_eq("call_b0", {56'h0, dbg_data}, 64'hBC);
    dbg_addr = 64'd1017; #1; check_eq("call_b1", {56'h0, dbg_data}, 64'h0A);
    do_op(4'h9, 64'd1016, 64'h0, 64'h0, 1'b0);
    do_op(4'h5, 64'h0, 64'd1017, 64'h0, 1'b0);
    check_mem("adr_unchanged", 1008, 1023);
    do_op(4'h5, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0);
    do_op(4'hA, rand64(), 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 1'b0);
    check_mem("adr_wr_unchanged", 0, 15);
    do_op(4'h0, 64'h0, 64'h0, 64'h0, 1'b0);
    do_op(4'hC, 64'h0, 64'h0, 64'h0, 1'b0);
    do_op(4'h6, rand64(), 64'd40, 64'h0, 1'b0);

    // pushq @32 aborted by reset in cycle 4, start held high meanwhile.
    d = 64'hA1B2_C3D4_E5F6_0718;
    @(negedge clk);
    icode = 4'hA; valA = d; valE = 64'd32; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) begin
        icode = 4'h5; valE = 64'd0;
      end else begin
        start = 1'b0; rst = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", {63'h0, busy}, 64'h0);
    check_eq("abort_done", {63'h0, done}, 64'h0);
    check_eq("abort_valM", valM, 64'h0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_eq("abort_no_done", 64'(ndone), 64'h0);
    for (int k = 0; k < 3; k++) model_mem[32 + k] = d[8*k +: 8];
    check_mem("abort_bytes", 32, 39);

    // Random instruction mix with occasional out-of-range addresses.
    for (int n = 0; n < 80; n++) begin
      ic = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0: ad = rand64();
        1: ad = 64'($urandom_range(1017, 1100));
        2: ad = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
        default: ad = 64'($urandom_range(0, 1016));
      endcase
      if (ic == 4'h9 || ic == 4'hB) begin
        d = ad; ea = rand64();
      end else begin
        d = rand64(); ea = ad;
      end
      do_op(ic, d, ea, rand64(), 1'($urandom_range(0, 1)));
    end
    check_mem("final_mem", 0, 63);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
